pad: RTL and testbench
======================

// Module: pad
// PURPOSE
//  Row padder at the input of the filter pipeline, the counterpart of the row clip at its output.
//  Takes the raw image pixel stream and, after every row of data, inserts WIDTH_NB-1 pad values.
//  The window/line buffers use the pad values to flush the last kernel positions of each row.
//  Padded row length is cfg_delay: (cfg_delay-WIDTH_NB+1) pixels, then (WIDTH_NB-1) pads.
//  With the same cfg_delay, the downstream clip discards exactly the values this block adds.
// PARAMETERS
//  WIDTH_NB    3               kernel width; pads per row = WIDTH_NB-1 (WIDTH_NB=1: no padding)
//  IMG_WIDTH   8               pixel data width
//  MEM_AWIDTH  12              width of row counter and cfg_delay
//  MEM_DEPTH   1<<MEM_AWIDTH   max padded row length (informational)
// PORTS
//  clk        in   1           clock
//  rst        in   1           reset, asynchronous, active-high
//  cfg_delay  in   MEM_AWIDTH  padded row length; sampled when cfg_set=1
//  cfg_pad    in   IMG_WIDTH   pad value; sampled when cfg_set=1
//  cfg_set    in   1           config strobe, one cycle
//  up_data    in   IMG_WIDTH   input pixel
//  up_val     in   1           input valid
//  up_rdy     out  1           input ready (combinational)
//  dn_data    out  IMG_WIDTH   output pixel/pad (registered)
//  dn_val     out  1           output valid (registered)
//  dn_rdy     in   1           output ready
// BEHAVIOUR
//  Reset values: dn_val=0, dn_data=0, state=IDLE, row_cnt=0, cfg regs=0. up_rdy=0 in reset.
//  Handshake: a beat transfers when val&rdy.
//   - dn_data/dn_val are held stable while dn_val=1 and dn_rdy=0.
//   - ld = !dn_val | dn_rdy. up_rdy = (state==PASS) & ld & !cfg_set.
//  Latency: 1 cycle from up transfer to dn_val. Throughput 1 beat/cycle with dn_rdy=1.
//  Config: on cfg_set, register cfg_pad, cfg_last=cfg_delay-1 and cfg_dlast=cfg_delay-WIDTH_NB.
//   - Also on cfg_set: row_cnt<=0 and dn_val<=0 (any unaccepted output is dropped).
//   - state<=PASS if cfg_delay>=WIDTH_NB, else IDLE; the block stays disabled until the next valid cfg_set.
//   - cfg_set has priority over every other event in the same cycle.
//  States:
//   - IDLE: up_rdy=0. dn_val clears once the held beat is accepted (ld).
//   - PASS, on up transfer: dn_data<=up_data, dn_val<=1.
//     If row_cnt==cfg_dlast: row_cnt<=0 when WIDTH_NB==1 (stay PASS), else row_cnt++ and go to PAD.
//     Otherwise row_cnt++.
//   - PASS, no up transfer and ld=1: dn_val<=0.
//   - PAD, when ld: dn_data<=cfg_pad, dn_val<=1, upstream stalled (up_rdy=0).
//     If row_cnt==cfg_last: row_cnt<=0 and go to PASS. Otherwise row_cnt++.
//  row_cnt counts output positions 0..cfg_delay-1 in the padded row and wraps to 0 at the row end.
//  It never exceeds cfg_last. Comparisons are unsigned, MEM_AWIDTH wide.
//  Pads are generated without any upstream input: a row ending with up_val=0 still gets its pads.
//  There is no frame concept: rows repeat until the next cfg_set.
//  Reset mid-row or mid-pad: all state returns to the reset values immediately (async); config must be reissued.
// TESTING
//  1. WIDTH_NB=3, cfg_delay=6, cfg_pad=8'hAA, inputs 1..8, dn_rdy=1
//     -> dn: 1,2,3,4,AA,AA,5,6,7,8,AA,AA. up_rdy=0 for exactly the 2 pad cycles per row.
//  2. Same config, dn_rdy random 50%, up_val random 50%, 40 pixels
//     -> dn sequence identical to the ideal model, no loss or duplication, dn_data stable while stalled.
//  3. cfg_delay=2 (<WIDTH_NB) -> up_rdy stays 0 and dn_val stays 0 for 20 cycles.
//     Then cfg_delay=4 -> rows of 2 pixels + 2 pads.
//  4. cfg_set asserted after 2 pixels of a row, with up_val=1 that cycle
//     -> no transfer that cycle, dn_val=0 next cycle, next row starts at row_cnt 0 with the new config.
//  5. rst asserted during the PAD state -> dn_val=0 and up_rdy=0 in the same cycle.
//     After release, no output until cfg_set.
//  6. WIDTH_NB=1 -> pure 1-cycle pass-through. Separately, pad->clip chain with equal cfg_delay
//     -> clip output equals the input pixel stream.

Source files
------------

// File: rtl/pad.sv
// pad: row padder at the head of the filter pipeline.
// It forwards the raw pixel stream and appends WIDTH_NB-1 pad values after each
// row, so a padded row is cfg_delay beats long. The window/line buffers use the
// pads to flush the last kernel positions of a row. The matching clip stage at
// the pipeline output drops those positions again.
module pad #(
    parameter int WIDTH_NB   = 3,
    parameter int IMG_WIDTH  = 8,
    parameter int MEM_AWIDTH = 12,
    parameter int MEM_DEPTH  = 1 << MEM_AWIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [MEM_AWIDTH-1:0] cfg_delay,
    input  logic [IMG_WIDTH-1:0]  cfg_pad,
    input  logic                  cfg_set,
    input  logic [IMG_WIDTH-1:0]  up_data,
    input  logic                  up_val,
    output logic                  up_rdy,
    output logic [IMG_WIDTH-1:0]  dn_data,
    output logic                  dn_val,
    input  logic                  dn_rdy
);

    typedef enum logic [1:0] {
        S_IDLE,  // unconfigured or configured with a row too short: no traffic
        S_PASS,  // forwarding pixels of the current row
        S_PAD    // emitting pad values at the end of the row
    } state_t;

    localparam logic [MEM_AWIDTH-1:0] WNB = MEM_AWIDTH'(WIDTH_NB);
    localparam logic [MEM_AWIDTH-1:0] ONE = MEM_AWIDTH'(1);

    state_t                state_q, state_d;
    logic [MEM_AWIDTH-1:0] row_cnt_q, row_cnt_d;
    logic [MEM_AWIDTH-1:0] cfg_last_q, cfg_last_d;    // last position of the padded row
    logic [MEM_AWIDTH-1:0] cfg_dlast_q, cfg_dlast_d;  // position of the last real pixel
    logic [IMG_WIDTH-1:0]  cfg_pad_q, cfg_pad_d;
    logic [IMG_WIDTH-1:0]  dn_data_d;
    logic                  dn_val_d;
    logic                  ld;
    logic                  up_xfer;

    // The output register can take a new beat when it is empty or being drained.
    assign ld      = !dn_val || dn_rdy;
    assign up_rdy  = (state_q == S_PASS) && ld && !cfg_set;
    assign up_xfer = up_val && up_rdy;

    // Next-state logic: config load, pixel pass-through and pad generation.
    always_comb begin
        // NOTE: every signal driven here gets its hold value first, so no branch
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        cfg_last_d  = cfg_last_q;
        cfg_dlast_d = cfg_dlast_q;
        cfg_pad_d   = cfg_pad_q;
        dn_data_d   = dn_data;
        dn_val_d    = dn_val;

        if (cfg_set) begin
            // A new configuration restarts the row and drops any pending output.
            cfg_pad_d   = cfg_pad;
            cfg_last_d  = cfg_delay - ONE;
            cfg_dlast_d = cfg_delay - WNB;
            row_cnt_d   = '0;
            dn_val_d    = 1'b0;
            state_d     = (cfg_delay >= WNB) ? S_PASS : S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (ld) begin
                        dn_val_d = 1'b0;
                    end
                end
                S_PASS: begin
                    if (up_xfer) begin
                        dn_data_d = up_data;
                        dn_val_d  = 1'b1;
                        if (row_cnt_q == cfg_dlast_q) begin
                            if (WIDTH_NB == 1) begin
                                row_cnt_d = '0;
                            end else begin
                                row_cnt_d = row_cnt_q + ONE;
                                state_d   = S_PAD;
                            end
                        end else begin
                            row_cnt_d = row_cnt_q + ONE;
                        end
                    end else if (ld) begin
                        dn_val_d = 1'b0;
                    end
                end
                S_PAD: begin
                    if (ld) begin
                        dn_data_d = cfg_pad_q;
                        dn_val_d  = 1'b1;
                        if (row_cnt_q == cfg_last_q) begin
                            row_cnt_d = '0;
                            state_d   = S_PASS;
                        end else begin
                            row_cnt_d = row_cnt_q + ONE;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, configuration and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            row_cnt_q   <= '0;
            cfg_last_q  <= '0;
            cfg_dlast_q <= '0;
            cfg_pad_q   <= '0;
            dn_data     <= '0;
            dn_val      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            cfg_last_q  <= cfg_last_d;
            cfg_dlast_q <= cfg_dlast_d;
            cfg_pad_q   <= cfg_pad_d;
            dn_data     <= dn_data_d;
            dn_val      <= dn_val_d;
        end
    end

    // A padded row longer than the line buffers cannot be flushed downstream.
    always_ff @(posedge clk) begin
        if (!rst && cfg_set) begin
            assert (int'(cfg_delay) <= MEM_DEPTH);
        end
    end

endmodule

// File: tb/tb_pad.sv
// tb_pad: directed bench for the row padder, with a WIDTH_NB=1 instance for the
// pass-through case and a clip model to check the pad->clip round trip.
module tb_pad;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] cfg_delay;
    logic [7:0]  cfg_pad;
    logic        cfg_set;
    logic [7:0]  up_data;
    logic        up_val;
    logic        up_rdy;
    logic [7:0]  dn_data;
    logic        dn_val;
    logic        dn_rdy;

    logic [11:0] cfg_delay1;
    logic [7:0]  cfg_pad1;
    logic        cfg_set1;
    logic [7:0]  up_data1;
    logic        up_val1;
    logic        up_rdy1;
    logic [7:0]  dn_data1;
    logic        dn_val1;
    logic        dn_rdy1;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          idx;
    logic [15:0] rdy_pat;
    logic [7:0]  src_q[$];
    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];

    pad #(.WIDTH_NB(3), .IMG_WIDTH(8), .MEM_AWIDTH(12)) u_dut (
        .clk(clk), .rst(rst),
        .cfg_delay(cfg_delay), .cfg_pad(cfg_pad), .cfg_set(cfg_set),
        .up_data(up_data), .up_val(up_val), .up_rdy(up_rdy),
        .dn_data(dn_data), .dn_val(dn_val), .dn_rdy(dn_rdy)
    );

    pad #(.WIDTH_NB(1), .IMG_WIDTH(8), .MEM_AWIDTH(12)) u_dut1 (
        .clk(clk), .rst(rst),
        .cfg_delay(cfg_delay1), .cfg_pad(cfg_pad1), .cfg_set(cfg_set1),
        .up_data(up_data1), .up_val(up_val1), .up_rdy(up_rdy1),
        .dn_data(dn_data1), .dn_val(dn_val1), .dn_rdy(dn_rdy1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Compare the recorded downstream beats against the expected queue.
    task automatic cmp_q(input string tag);
        check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    // One-cycle config strobe; starts and ends just after a rising edge.
    task automatic cfg(input logic [11:0] d, input logic [7:0] p);
        cfg_set   = 1'b1;
        cfg_delay = d;
        cfg_pad   = p;
        up_val    = 1'b0;
        @(posedge clk); #1;
        cfg_set   = 1'b0;
    endtask

    // Drive src_q with the given valid/ready percentages and record dn beats.
    task automatic run(input int ncyc, input int pval, input int prdy,
                       input bit stab, input int want);
        bit         stall_prev = 1'b0;
        logic [7:0] held = 8'h00;
        for (int c = 0; c < ncyc && got_q.size() < want; c++) begin
            up_val  = (idx < src_q.size()) && ($urandom_range(99) < pval);
            up_data = 8'h00;
            if (up_val) up_data = src_q[idx];
            dn_rdy  = ($urandom_range(99) < prdy);
            @(negedge clk);
            if (stab && stall_prev) begin
                check("t2_hold_val", 32'(dn_val), 32'd1);
                check("t2_hold_data", 32'(dn_data), 32'(held));
            end
            stall_prev = dn_val && !dn_rdy;
            held       = dn_data;
            rdy_pat    = {rdy_pat[14:0], up_rdy};
            if (dn_val && dn_rdy) got_q.push_back(dn_data);
            if (up_val && up_rdy) idx++;
            @(posedge clk); #1;
        end
        up_val = 1'b0;
    endtask

    task automatic restart(input int first, input int n);
        src_q.delete();
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < n; i++) src_q.push_back(8'(first + i));
        idx = 0;
    endtask

    // Idle cycles with up_val held high; returns whether anything moved.
    task automatic idle_seen(input int ncyc, output logic seen);
        seen = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            up_val  = 1'b1;
            up_data = 8'h99;
            dn_rdy  = 1'b1;
            @(negedge clk);
            seen = seen | up_rdy | dn_val;
            @(posedge clk); #1;
        end
        up_val = 1'b0;
    endtask

    initial begin
        logic        seen;
        logic        pv;
        logic [7:0]  pd;
        logic [11:0] pat1;
        int          nerr;
        logic [7:0]  clip_q[$];

        rst = 1'b1;
        cfg_set = 1'b0; cfg_delay = '0; cfg_pad = '0;
        up_val = 1'b1; up_data = 8'h12; dn_rdy = 1'b1;
        cfg_set1 = 1'b0; cfg_delay1 = '0; cfg_pad1 = '0;
        up_val1 = 1'b0; up_data1 = '0; dn_rdy1 = 1'b1;
        rdy_pat = '0;
        idx = 0;

        // Reset state.
        @(posedge clk); #1;
        check("rst_dn_val", 32'(dn_val), 32'd0);
        check("rst_dn_data", 32'(dn_data), 32'd0);
        check("rst_up_rdy", 32'(up_rdy), 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("unconfigured_up_rdy", 32'(up_rdy), 32'd0);
        up_val = 1'b0;

        // 1: two rows of 4 pixels + 2 pads at full throughput.
        cfg(12'd6, 8'hAA);
        restart(1, 8);
        rdy_pat = '0;
        run(16, 100, 100, 1'b0, 999);
        exp_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'hAA, 8'hAA,
                 8'h05, 8'h06, 8'h07, 8'h08, 8'hAA, 8'hAA};
        cmp_q("t1");
        check("t1_up_rdy_pattern", 32'(rdy_pat), 32'(16'b1111_0011_1100_1111));

        // 2: random stalls on both sides against the ideal row model.
        cfg(12'd6, 8'hAA);
        restart(100, 40);
        for (int i = 0; i < 40; i++) begin
            exp_q.push_back(src_q[i]);
            if ((i % 4) == 3) begin
                exp_q.push_back(8'hAA);
                exp_q.push_back(8'hAA);
            end
        end
        run(2000, 50, 50, 1'b1, 60);
        run(10, 100, 100, 1'b0, 999);
        cmp_q("t2");

        // 6b: clip model with the same cfg_delay restores the pixel stream.
        clip_q.delete();
        for (int k = 0; k < got_q.size(); k++)
            if ((k % 6) < 4) clip_q.push_back(got_q[k]);
        nerr = 0;
        for (int k = 0; k < clip_q.size() && k < src_q.size(); k++)
            if (clip_q[k] !== src_q[k]) nerr++;
        check("t6_clip_len", 32'(clip_q.size()), 32'(src_q.size()));
        check("t6_clip_errors", 32'(nerr), 32'd0);

        // 3: a row shorter than the kernel disables the block.
        cfg(12'd2, 8'h55);
        idle_seen(20, seen);
        check("t3_disabled", 32'(seen), 32'd0);
        cfg(12'd4, 8'h55);
        restart(1, 4);
        run(12, 100, 100, 1'b0, 999);
        exp_q = {8'h01, 8'h02, 8'h55, 8'h55, 8'h03, 8'h04, 8'h55, 8'h55};
        cmp_q("t3");

        // 4: reconfigure mid-row with a pixel offered in the same cycle.
        cfg(12'd6, 8'hAA);
        restart(1, 2);
        run(2, 100, 100, 1'b0, 999);
        cfg_set = 1'b1; cfg_delay = 12'd5; cfg_pad = 8'h77;
        up_val = 1'b1; up_data = 8'h33; dn_rdy = 1'b0;
        @(negedge clk);
        check("t4_cfg_up_rdy", 32'(up_rdy), 32'd0);
        @(posedge clk); #1;
        cfg_set = 1'b0; up_val = 1'b0; dn_rdy = 1'b1;
        @(negedge clk);
        check("t4_dn_val_dropped", 32'(dn_val), 32'd0);
        @(posedge clk); #1;
        src_q.delete();
        for (int i = 0; i < 6; i++) src_q.push_back(8'(8'h10 + i));
        idx = 0;
        run(16, 100, 100, 1'b0, 999);
        exp_q = {8'h01, 8'h10, 8'h11, 8'h12, 8'h77, 8'h77,
                 8'h13, 8'h14, 8'h15, 8'h77, 8'h77};
        cmp_q("t4");

        // 5: asynchronous reset while padding.
        cfg(12'd6, 8'hAA);
        restart(1, 4);
        run(4, 100, 100, 1'b0, 999);
        up_val = 1'b1; up_data = 8'h05; dn_rdy = 1'b1;
        #1;
        check("t5_pad_up_rdy", 32'(up_rdy), 32'd0);
        check("t5_pad_dn_val", 32'(dn_val), 32'd1);
        rst = 1'b1;
        #1;
        check("t5_rst_dn_val", 32'(dn_val), 32'd0);
        check("t5_rst_up_rdy", 32'(up_rdy), 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        idle_seen(10, seen);
        check("t5_no_output_after_rst", 32'(seen), 32'd0);
        cfg(12'd6, 8'hAA);
        restart(7, 4);
        run(10, 100, 100, 1'b0, 999);
        exp_q = {8'h07, 8'h08, 8'h09, 8'h0A, 8'hAA, 8'hAA};
        cmp_q("t5_recover");

        // 6a: WIDTH_NB=1 is a plain one-cycle pass-through.
        cfg_set1 = 1'b1; cfg_delay1 = 12'd4; cfg_pad1 = 8'hEE;
        @(posedge clk); #1;
        cfg_set1 = 1'b0; dn_rdy1 = 1'b1;
        pat1 = 12'b1101_1101_1111;
        pv = 1'b0; pd = 8'h00;
        for (int c = 0; c < 12; c++) begin
            up_val1  = pat1[11-c];
            up_data1 = 8'(8'h20 + c);
            @(negedge clk);
            check($sformatf("t6_up_rdy_%0d", c), 32'(up_rdy1), 32'd1);
            check($sformatf("t6_dn_val_%0d", c), 32'(dn_val1), 32'(pv));
            if (pv) check($sformatf("t6_dn_data_%0d", c), 32'(dn_data1), 32'(pd));
            pv = up_val1;
            pd = up_data1;
            @(posedge clk); #1;
        end
        up_val1 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
